// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with busy scoreboard, immediate extender and ID/EX output register.
// Optional write-back forwarding into decode is enabled by defining REGFILE_BYPASS_EN.
module id_regfile_scoreboard #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SP_IDX  = 29,
  parameter int unsigned SP_INIT = 4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instruction,
  input  logic              id_valid,
  input  logic              ext_zero,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              flush,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] write_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] extended_bits
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [5:0]        unused_opcode;

  logic fwd_rs;
  logic fwd_rt;
  logic fwd_dst;
  logic busy_rs;
  logic busy_rt;
  logic busy_dst;
  logic accept;
  logic wb_en;

  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic [DATA_W-1:0] imm_ext;

  assign rs            = ADDR_W'(instruction[25:21]);
  assign rt            = ADDR_W'(instruction[20:16]);
  assign unused_opcode = instruction[31:26];

  assign wb_en = RegWrite && (write_register != '0);

`ifdef REGFILE_BYPASS_EN
  assign fwd_rs  = wb_en && (write_register == rs);
  assign fwd_rt  = wb_en && (write_register == rt);
  assign fwd_dst = wb_en && (write_register == issue_dst);
`else
  assign fwd_rs  = 1'b0;
  assign fwd_rt  = 1'b0;
  assign fwd_dst = 1'b0;
`endif

  // A register being written back this cycle is only free when it can be forwarded.
  assign busy_rs  = (rs != '0) && busy[rs] && !fwd_rs;
  assign busy_rt  = (rt != '0) && busy[rt] && !fwd_rt;
  assign busy_dst = (issue_dst != '0) && busy[issue_dst] && !fwd_dst;

  assign stall  = id_valid && (busy_rs || busy_rt || (issue_wr && busy_dst));
  assign accept = id_valid && !stall && !flush;

  always_comb begin
    operand1 = '0;
    if (rs != '0) begin
      operand1 = fwd_rs ? write_data : regs[rs];
    end
  end

  always_comb begin
    operand2 = '0;
    if (rt != '0) begin
      operand2 = fwd_rt ? write_data : regs[rt];
    end
  end

  always_comb begin
    imm_ext       = {DATA_W{!ext_zero && instruction[15]}};
    imm_ext[15:0] = instruction[15:0];
  end

  // Clear first, then set, so a same-cycle issue to the written register stays busy.
  always_comb begin
    busy_next = busy;
    if (wb_en) begin
      busy_next[write_register] = 1'b0;
    end
    if (accept && issue_wr && (issue_dst != '0)) begin
      busy_next[issue_dst] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      end
    end else if (wb_en) begin
      regs[write_register] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      read_data1    <= '0;
      read_data2    <= '0;
      extended_bits <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        read_data1    <= operand1;
        read_data2    <= operand2;
        extended_bits <= imm_ext;
      end
    end
  end

endmodule
